gpmc_wb_master: RTL and testbench

GPMC_WB_MASTER -- requirements
Module: gpmc_wb_master

---
 rtl/gpmc_wb_master_pkg.sv | 17 +
 rtl/gpmc_wb_timeout.sv | 31 +++
 rtl/gpmc_wb_master.sv | 180 ++++++++++++++++++
 tb/tb_gpmc_wb_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpmc_wb_master_pkg.sv
// Shared definitions for the GPMC-to-Wishbone bridge: state encoding,
// bus width, timeout counter width and default error read data.
package gpmc_wb_master_pkg;

  localparam int GPMC_DW = 16;
  localparam int TMO_W   = 9;

  localparam logic [GPMC_DW-1:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/gpmc_wb_timeout.sv
// Wishbone cycle watchdog: counts cycles while enabled, restarts from zero
// whenever disabled, and flags expiry when the count reaches LIMIT.
module gpmc_wb_timeout
  import gpmc_wb_master_pkg::*;
#(
  parameter int LIMIT = 254
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] C_LIMIT = LIMIT[TMO_W-1:0];

  logic [TMO_W-1:0] r_cnt;

  // Count cycles spent in the Wishbone state; idle time holds the counter at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == C_LIMIT);

endmodule

// File: rtl/gpmc_wb_master.sv
// GPMC (muxed address/data, async host) to Wishbone single-cycle master.
// One Wishbone cycle is issued per chip-select assertion; the host is
// stalled through GPMC_WAIT while the cycle is outstanding.
module gpmc_wb_master
  import gpmc_wb_master_pkg::*;
#(
  parameter int                 TIMEOUT  = 255,
  parameter logic [GPMC_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic               GPMC_CLK,
  input  logic               RST_N,
  input  logic               GPMC_CSN,
  input  logic               GPMC_ADVN,
  input  logic               GPMC_OEN,
  input  logic               GPMC_WEN,
  input  logic [GPMC_DW-1:0] GPMC_AD_I,
  output logic [GPMC_DW-1:0] GPMC_AD_O,
  output logic               GPMC_AD_OE,
  output logic               GPMC_WAIT,
  output logic [GPMC_DW-1:0] WB_ADR_O,
  output logic [GPMC_DW-1:0] WB_DAT_O,
  input  logic [GPMC_DW-1:0] WB_DAT_I,
  output logic               WB_WE_O,
  output logic               WB_CYC_O,
  output logic               WB_STB_O,
  input  logic               WB_ACK_I,
  output logic               ERR,
  input  logic               ERR_CLR
);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_t             r_state;
  state_t             w_next;
  logic [GPMC_DW-1:0] r_adr;
  logic [GPMC_DW-1:0] r_dat;
  logic [GPMC_DW-1:0] r_rdata;
  logic               r_we;
  logic               r_err;
  logic               r_abort;
  logic               w_in_wb;
  logic               w_expired;
  logic               w_ld_adr;
  logic               w_ld_dat;
  logic               w_we_set;
  logic               w_we_clr;
  logic               w_cap_rd;
  logic               w_cap_err;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge GPMC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];
  assign w_in_wb = (r_state == ST_WB);

  gpmc_wb_timeout #(
    .LIMIT (TIMEOUT - 1)
  ) u_timeout (
    .i_clk     (GPMC_CLK),
    .i_rst_n   (w_rst_n),
    .i_en      (w_in_wb),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge GPMC_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    w_next    = r_state;
    w_ld_adr  = 1'b0;
    w_ld_dat  = 1'b0;
    w_we_set  = 1'b0;
    w_we_clr  = 1'b0;
    w_cap_rd  = 1'b0;
    w_cap_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!GPMC_CSN && !GPMC_ADVN) begin
          w_ld_adr = 1'b1;
          w_next   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A write strobe takes priority over a simultaneous read strobe.
        if (!GPMC_WEN) begin
          w_ld_dat = 1'b1;
          w_we_set = 1'b1;
          w_next   = ST_WB;
        end else if (!GPMC_OEN) begin
          w_we_clr = 1'b1;
          w_next   = ST_WB;
        end else if (GPMC_CSN) begin
          w_next = ST_IDLE;
        end
      end
      ST_WB: begin
        // ACK beats a coincident expiry; a host that dropped CSN skips DONE.
        if (WB_ACK_I) begin
          w_cap_rd = !r_we;
          w_next   = (r_abort || GPMC_CSN) ? ST_IDLE : ST_DONE;
        end else if (w_expired) begin
          w_cap_err = 1'b1;
          w_next    = (r_abort || GPMC_CSN) ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (GPMC_CSN) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address, write data, direction and read-return registers.
  always_ff @(posedge GPMC_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_ld_adr) r_adr <= GPMC_AD_I;
      if (w_ld_dat) r_dat <= GPMC_AD_I;
      if (w_we_set) begin
        r_we <= 1'b1;
      end else if (w_we_clr) begin
        r_we <= 1'b0;
      end
      if (w_cap_rd) begin
        r_rdata <= WB_DAT_I;
      end else if (w_cap_err) begin
        r_rdata <= ERR_DATA;
      end
    end
  end

  // Sticky timeout flag (set wins over clear) and host-abort tracking during WB.
  always_ff @(posedge GPMC_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (w_cap_err) begin
        r_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_err <= 1'b0;
      end
      if (!w_in_wb) begin
        r_abort <= 1'b0;
      end else if (GPMC_CSN) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign WB_ADR_O   = r_adr;
  assign WB_DAT_O   = r_dat;
  assign WB_WE_O    = r_we;
  assign WB_CYC_O   = w_in_wb;
  assign WB_STB_O   = w_in_wb;
  assign GPMC_WAIT  = w_in_wb;
  assign GPMC_AD_O  = r_rdata;
  assign GPMC_AD_OE = (r_state == ST_DONE) && !r_we && !GPMC_OEN;
  assign ERR        = r_err;

endmodule

// File: tb/tb_gpmc_wb_master.sv
// Bench for gpmc_wb_master: a GPMC host driver, a Wishbone slave with a
// programmable ACK delay, a bus monitor, and a transaction-level model of
// what each access should produce.
module tb_gpmc_wb_master;

  localparam int          TMO   = 255;
  localparam logic [15:0] EDATA = 16'hDEAD;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        csn     = 1'b1;
  logic        advn    = 1'b1;
  logic        oen     = 1'b1;
  logic        wen     = 1'b1;
  logic [15:0] ad_i    = 16'h0000;
  logic        err_clr = 1'b0;
  logic [15:0] wb_dati = 16'h0000;
  logic        wb_ack  = 1'b0;
  logic [15:0] ad_o;
  logic        ad_oe;
  logic        gwait;
  logic [15:0] wb_adr;
  logic [15:0] wb_dato;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        err;

  always #5 clk = ~clk;

  gpmc_wb_master #(
    .TIMEOUT  (TMO),
    .ERR_DATA (EDATA)
  ) dut (
    .GPMC_CLK   (clk),
    .RST_N      (rst_n),
    .GPMC_CSN   (csn),
    .GPMC_ADVN  (advn),
    .GPMC_OEN   (oen),
    .GPMC_WEN   (wen),
    .GPMC_AD_I  (ad_i),
    .GPMC_AD_O  (ad_o),
    .GPMC_AD_OE (ad_oe),
    .GPMC_WAIT  (gwait),
    .WB_ADR_O   (wb_adr),
    .WB_DAT_O   (wb_dato),
    .WB_DAT_I   (wb_dati),
    .WB_WE_O    (wb_we),
    .WB_CYC_O   (wb_cyc),
    .WB_STB_O   (wb_stb),
    .WB_ACK_I   (wb_ack),
    .ERR        (err),
    .ERR_CLR    (err_clr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor / slave state (written only by the monitor process).
  int          mon_len      = 0;
  int          mon_ncyc     = 0;
  int          mon_wait_bad = 0;
  int          mon_bad      = 0;
  logic [15:0] mon_adr      = 16'h0000;
  logic [15:0] mon_dat      = 16'h0000;
  logic        mon_we       = 1'b0;
  logic        prev_cyc     = 1'b0;

  // Slave configuration (written only by the host process).
  int          ack_dly = 0;
  logic [15:0] rd_val  = 16'h0000;

  // Transaction-level expectations.
  logic [15:0] model_rd  = 16'h0000;
  logic        model_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave and bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (gwait !== wb_cyc) mon_wait_bad++;
    if (wb_cyc === 1'b1) begin
      if (!prev_cyc) begin
        mon_ncyc++;
        mon_len = 0;
        mon_adr = wb_adr;
        mon_dat = wb_dato;
        mon_we  = wb_we;
      end
      mon_len++;
      if (wb_stb !== 1'b1 || ad_oe !== 1'b0) mon_bad++;
      wb_ack = (ack_dly != 0) && (mon_len == ack_dly);
    end else begin
      wb_ack = 1'b0;
    end
    wb_dati  = wb_ack ? rd_val : ~rd_val;
    prev_cyc = (wb_cyc === 1'b1);
  end

  // One host access; dly=0 means the slave never acknowledges.
  task automatic access(input bit wr, input bit both, input logic [15:0] adr,
                        input logic [15:0] dat, input int dly,
                        input bit clr_hold, input bit abort_mid);
    int  base;
    bit  seen;
    bit  acked;
    int  exp_len;
    base    = mon_ncyc;
    ack_dly = dly;
    rd_val  = dat;
    @(negedge clk);
    csn = 1'b0; advn = 1'b0; ad_i = adr;
    @(negedge clk);
    advn = 1'b1;
    ad_i = wr ? dat : 16'($urandom);
    if (wr) wen = 1'b0;
    if (!wr || both) oen = 1'b0;
    if (clr_hold) err_clr = 1'b1;
    #1 check("addr_phase_no_cyc", 32'(wb_cyc), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (wb_cyc === 1'b1) seen = 1'b1;
      if (abort_mid && seen && i == 2) begin
        csn = 1'b1; oen = 1'b1; wen = 1'b1;
      end
      if (seen && wb_cyc === 1'b0) break;
    end
    err_clr = 1'b0;
    check("cycle_completed", 32'(seen && wb_cyc === 1'b0), 32'd1);

    acked   = (dly >= 1) && (dly <= TMO);
    exp_len = acked ? dly : TMO;
    if (clr_hold) model_err = 1'b0;
    if (!acked) begin
      model_err = 1'b1;
      model_rd  = EDATA;
    end else if (!wr) begin
      model_rd = dat;
    end

    check("one_wb_cycle", 32'(mon_ncyc - base), 32'd1);
    check("cyc_length",   32'(mon_len), 32'(exp_len));
    check("wb_adr",       32'(mon_adr), 32'(adr));
    check("wb_we",        32'(mon_we), 32'(wr));
    if (wr) check("wb_dat_o", 32'(mon_dat), 32'(dat));
    check("wait_tracks_cyc", 32'(mon_wait_bad), 32'd0);
    check("stb_oe_in_wb",    32'(mon_bad), 32'd0);
    check("err_flag",        32'(err), 32'(model_err));
    check("ad_o",            32'(ad_o), 32'(model_rd));

    if (abort_mid) begin
      oen = 1'b0;
      #1 check("abort_skips_done", 32'(ad_oe), 32'd0);
      oen = 1'b1;
    end else begin
      check("ad_oe_done", 32'(ad_oe), 32'(!wr));
      oen = 1'b1;
      #1 check("ad_oe_drops_on_oen", 32'(ad_oe), 32'd0);
      csn = 1'b1; wen = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int base;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_cyc",   32'(wb_cyc), 32'd0);
    check("rst_wait",  32'(gwait),  32'd0);
    check("rst_err",   32'(err),    32'd0);
    check("rst_adr",   32'(wb_adr), 32'd0);
    check("rst_ad_o",  32'(ad_o),   32'd0);
    check("rst_ad_oe", 32'(ad_oe),  32'd0);

    // Basic write and read.
    access(1'b1, 1'b0, 16'h0040, 16'h1234, 3, 1'b0, 1'b0);
    access(1'b0, 1'b0, 16'h0008, 16'hBEEF, 2, 1'b0, 1'b0);

    // Read timeout, then clear the sticky flag.
    access(1'b0, 1'b0, 16'h0100, 16'h5555, 0, 1'b0, 1'b0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1 check("err_clr", 32'(err), 32'd0);
    model_err = 1'b0;

    // ACK on the expiry cycle beats the timeout.
    access(1'b0, 1'b0, 16'h0200, 16'hCAFE, TMO, 1'b0, 1'b0);

    // Write and read strobes together: write wins.
    access(1'b1, 1'b1, 16'h0300, 16'hA5A5, 4, 1'b0, 1'b0);

    // Timeout while ERR_CLR is held: set wins.
    access(1'b1, 1'b0, 16'h0400, 16'h0F0F, 0, 1'b1, 1'b0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1 check("err_clr_2", 32'(err), 32'd0);
    model_err = 1'b0;

    // CSN dropped in the address phase: no Wishbone cycle.
    base = mon_ncyc;
    @(negedge clk); csn = 1'b0; advn = 1'b0; ad_i = 16'h7777;
    @(negedge clk); csn = 1'b1; advn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("addr_abort_no_cyc", 32'(mon_ncyc - base), 32'd0);
    check("addr_abort_adr",    32'(wb_adr), 32'h7777);

    // CSN dropped mid-cycle: cycle finishes, FSM returns straight to IDLE.
    access(1'b0, 1'b0, 16'h0500, 16'h1357, 6, 1'b0, 1'b1);

    // Randomized accesses.
    for (int k = 0; k < 16; k++) begin
      access(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             16'($urandom), 16'($urandom), $urandom_range(12, 1), 1'b0, 1'b0);
    end

    // Reset asserted during an outstanding cycle.
    ack_dly = 0;
    @(negedge clk); csn = 1'b0; advn = 1'b0; ad_i = 16'h0900;
    @(negedge clk); advn = 1'b1; oen = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("pre_reset_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cyc",  32'(wb_cyc), 32'd0);
    check("async_rst_stb",  32'(wb_stb), 32'd0);
    check("async_rst_wait", 32'(gwait),  32'd0);
    check("async_rst_adr",  32'(wb_adr), 32'd0);
    check("async_rst_ad_o", 32'(ad_o),   32'd0);
    csn = 1'b1; oen = 1'b1;
    repeat (3) @(negedge clk);

    // Release with the host already addressing: first edge is still held in reset.
    rst_n = 1'b1; csn = 1'b0; advn = 1'b0; ad_i = 16'h5A5A;
    @(negedge clk);
    #1 check("sync_release_hold", 32'(wb_adr), 32'd0);
    repeat (2) @(negedge clk);
    #1 check("sync_release_run", 32'(wb_adr), 32'h5A5A);
    csn = 1'b1; advn = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("post_reset_no_cyc", 32'(wb_cyc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
